serial_pattern_tx: RTL

Serial bit-stream transmitter. It is the sending end of the single-bit serial interface consumed by the team's sequence-detector FSMs. It accepts parallel words with a length field over a valid/ready handshake and shifts them out one bit per clock with a bit_valid qualifier. A one-entry holding register lets consecutive words stream with no gap, so the block can drive detector benches and datapaths with patterns such as 1011 and 1011011.

---
 rtl/serial_tx_pkg.sv | 20 ++
 rtl/tx_hold_reg.sv | 49 ++++
 rtl/serial_pattern_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared state type and length helpers for the serial pattern transmitter
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  function automatic int len_w(input int width);
    return $clog2(width + 1);
  endfunction

  // A zero length means a full word; anything longer than the word is clamped.
  function automatic int eff_len(input int len, input int width);
    if (len == 0 || len > width) return width;
    return len;
  endfunction

endpackage

// File: rtl/tx_hold_reg.sv
// rtl/tx_hold_reg.sv - one-entry data/length holding register with full flag and registered ready
module tx_hold_reg #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             drain_i,
  output logic             full_o,
  output logic             full_next_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic [LEN_W-1:0] len_o
);

  logic             full_q;
  logic             full_d;
  logic             ready_q;
  logic [WIDTH-1:0] data_q;
  logic [LEN_W-1:0] len_q;

  assign full_d = load_i | (full_q & ~drain_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      data_q  <= '0;
      len_q   <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ~full_d;
      if (load_i) begin
        data_q <= data_i;
        len_q  <= len_i;
      end
    end
  end

  assign full_o      = full_q;
  assign full_next_o = full_d;
  assign ready_o     = ready_q;
  assign data_o      = data_q;
  assign len_o       = len_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - parallel-to-serial pattern transmitter with one-word hold and optional inter-word gap
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   GAP_CYCLES = 0,
  parameter bit   MSB_FIRST  = 1'b1,
  localparam int  LEN_W      = len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [LEN_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             bit_out_q, bit_valid_q, busy_q, done_q;

  logic             accept;
  logic             shift_load, use_hold, hold_load, hold_drain, done_d;
  logic             hold_full, hold_full_d, hold_ready;
  logic [WIDTH-1:0] hold_data;
  logic [LEN_W-1:0] hold_len;
  logic [LEN_W-1:0] in_len;
  logic [WIDTH-1:0] src_data, aligned, rest;
  logic [LEN_W-1:0] src_len;
  logic             first_bit;

  assign accept = load_valid && hold_ready;
  assign in_len = LEN_W'(eff_len(int'(len_in), WIDTH));

  tx_hold_reg #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .load_i      (hold_load),
    .data_i      (data_in),
    .len_i       (in_len),
    .drain_i     (hold_drain),
    .full_o      (hold_full),
    .full_next_o (hold_full_d),
    .ready_o     (hold_ready),
    .data_o      (hold_data),
    .len_o       (hold_len)
  );

  always_comb begin
    state_d    = state_q;
    shift_load = 1'b0;
    use_hold   = 1'b0;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_load = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          hold_load = accept;
        end else begin
          done_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            // Word boundary with no gap: hold first, else bypass the fresh load straight in.
            if (hold_full) begin
              shift_load = 1'b1;
              use_hold   = 1'b1;
              hold_drain = 1'b1;
            end else if (accept) begin
              shift_load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            if (hold_full || accept) begin
              hold_load = accept;
              state_d   = GAP;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          if (hold_full) begin
            shift_load = 1'b1;
            use_hold   = 1'b1;
            hold_drain = 1'b1;
            state_d    = SHIFT;
          end else if (accept) begin
            shift_load = 1'b1;
            state_d    = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_load = accept;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Left-justify MSB-first words so the next bit is always at the shifter's top.
  always_comb begin
    src_data  = use_hold ? hold_data : data_in;
    src_len   = use_hold ? hold_len : in_len;
    aligned   = MSB_FIRST ? (src_data << (WIDTH - int'(src_len))) : src_data;
    first_bit = MSB_FIRST ? aligned[WIDTH-1] : aligned[0];
    rest      = MSB_FIRST ? (aligned << 1) : (aligned >> 1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gap_cnt_q   <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE) || hold_full_d;

      if (shift_load) begin
        shreg_q     <= rest;
        cnt_q       <= src_len - LEN_W'(1);
        bit_out_q   <= first_bit;
        bit_valid_q <= 1'b1;
      end else if (state_q == SHIFT && cnt_q != '0) begin
        bit_out_q   <= MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        shreg_q     <= MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        cnt_q       <= cnt_q - LEN_W'(1);
        bit_valid_q <= 1'b1;
      end else begin
        bit_out_q   <= 1'b0;
        bit_valid_q <= 1'b0;
      end

      if (state_q == SHIFT && state_d == GAP) begin
        gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
      end else if (state_q == GAP && gap_cnt_q != '0) begin
        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
      end
    end
  end

  assign load_ready = hold_ready;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
